// File: rtl/jtpopeye_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtpopeye_pkg
//  Brief    : Shared constants and layer transparency rules for the colour
//             mixer: palette map bases, RGB field widths.
//  Revision : 1.0 - initial release
// ============================================================================
package jtpopeye_pkg;

    // Palette map bases: background (two banks of 16), object, text
    localparam logic [6:0] PAL_BCK = 7'h00;
    localparam logic [6:0] PAL_OBJ = 7'h20;
    localparam logic [6:0] PAL_TXT = 7'h40;

    // 3:3:2 output format, packed in the palette byte as {blue, green, red}
    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;

    // Text colour 0 is see-through
    function automatic logic txt_opaque(input logic [3:0] txtc);
        return txtc != 4'd0;
    endfunction

    // Object pixels with a zero low pair are see-through
    function automatic logic obj_opaque(input logic [4:0] objc);
        return objc[1:0] != 2'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtgng_ram.sv
`default_nettype none
// ============================================================================
//  Module   : jtgng_ram
//  Brief    : Single-port RAM, synchronous write and synchronous read with
//             one clk of read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module jtgng_ram #(
    parameter int aw = 7,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic [aw-1:0] i_addr,
    input  logic [dw-1:0] i_data,
    input  logic          i_we,
    output logic [dw-1:0] o_q
);

    logic [dw-1:0] r_mem [0:(1<<aw)-1];

    // Write-first is not needed: the read sees the old word on a write clk
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_data;
        o_q <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/jtpopeye_colmix_prio.sv
`default_nettype none
// ============================================================================
//  Module   : jtpopeye_colmix_prio
//  Brief    : Combinational layer priority (text > object > background) and
//             palette address formation. Also flags a masked background as
//             forced black.
//  Revision : 1.0 - initial release
// ============================================================================
module jtpopeye_colmix_prio
    import jtpopeye_pkg::*;
(
    input  logic       i_bank,
    input  logic [3:0] i_bakc,
    input  logic [4:0] i_objc,
    input  logic [3:0] i_txtc,
    input  logic [2:0] i_gfx_en,
    output logic [6:0] o_addr,
    output logic       o_black
);

    // Highest-priority opaque, enabled layer picks the palette entry
    always_comb begin
        o_addr  = PAL_BCK | {2'b00, i_bank, i_bakc};
        o_black = ~i_gfx_en[0];
        if (i_gfx_en[2] && txt_opaque(i_txtc)) begin
            o_addr  = PAL_TXT | {3'b000, i_txtc};
            o_black = 1'b0;
        end else if (i_gfx_en[1] && obj_opaque(i_objc)) begin
            o_addr  = PAL_OBJ | {2'b00, i_objc};
            o_black = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtpopeye_colmix.sv
`default_nettype none
// ============================================================================
//  Module   : jtpopeye_colmix
//  Brief    : Final pixel stage. Resolves layer priority, applies the CPU
//             background bank, reads the downloadable 128x8 palette and
//             emits 3:3:2 RGB with blanking delayed to match the pipeline.
//             Optional: define JTPOPEYE_LAYER_MASK_EN to add gfx_en[2:0]
//             (bit0 background, bit1 object, bit2 text).
//  Revision : 1.0 - initial release
// ============================================================================
module jtpopeye_colmix
    import jtpopeye_pkg::*;
#(
    parameter int BLANK_DLY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pxl_cen,
    input  logic               cpu_cen,
    input  logic               pal_cs_n,
    input  logic [7:0]         DD,
    input  logic [4:0]         BAKC,
    input  logic [4:0]         OBJC,
    input  logic [3:0]         TXTC,
    input  logic               HB,
    input  logic               VB,
    input  logic [6:0]         prog_addr,
    input  logic [7:0]         prog_data,
    input  logic               prom_we,
    input  logic               downloading,
`ifdef JTPOPEYE_LAYER_MASK_EN
    input  logic [2:0]         gfx_en,
`endif
    output logic [RED_W-1:0]   red,
    output logic [GREEN_W-1:0] green,
    output logic [BLUE_W-1:0]  blue,
    output logic               HB_out,
    output logic               VB_out
);

    logic       r_bank;
    logic [6:0] r_pal_addr;
    logic       r_black;
    logic [1:0] r_blank_dly [BLANK_DLY];  // {HB, VB} per stage
    logic [RED_W-1:0]   r_red;
    logic [GREEN_W-1:0] r_green;
    logic [BLUE_W-1:0]  r_blue;

    logic [2:0] w_gfx_en;
    logic [6:0] w_addr;
    logic       w_black;
    logic [6:0] w_ram_addr;
    logic       w_ram_we;
    logic [7:0] w_pal_q;
    logic       w_blank;
    logic       w_unused;

`ifdef JTPOPEYE_LAYER_MASK_EN
    assign w_gfx_en = gfx_en;
`else
    assign w_gfx_en = 3'b111;
`endif

    // BAKC[4] and the upper CPU data bits carry nothing for this block
    assign w_unused = &{1'b0, BAKC[4], DD[7:1]};

    jtpopeye_colmix_prio u_prio (
        .i_bank   (r_bank),
        .i_bakc   (BAKC[3:0]),
        .i_objc   (OBJC),
        .i_txtc   (TXTC),
        .i_gfx_en (w_gfx_en),
        .o_addr   (w_addr),
        .o_black  (w_black)
    );

    // Download owns the palette port; otherwise it only ever reads
    assign w_ram_addr = downloading ? prog_addr : r_pal_addr;
    assign w_ram_we   = downloading & prom_we;

    jtgng_ram #(.aw(7), .dw(8)) u_pal (
        .clk    (clk),
        .i_addr (w_ram_addr),
        .i_data (prog_data),
        .i_we   (w_ram_we),
        .o_q    (w_pal_q)
    );

    // CPU bank register; stage 1 sees the value held before this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_bank <= 1'b0;
        else if (cpu_cen && !pal_cs_n) r_bank <= DD[0];
    end

    // Stage 1: latch the selected palette address and the black override
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pal_addr <= 7'd0;
            r_black    <= 1'b0;
        end else if (pxl_cen) begin
            r_pal_addr <= w_addr;
            r_black    <= w_black;
        end
    end

    // Blanking delay line: first stage samples HB/VB, the last drives
    // HB_out/VB_out and resets to "blanked"
    generate
        for (genvar i = 0; i < BLANK_DLY; i++) begin : g_blank_dly
            localparam logic [1:0] c_rst = (i == BLANK_DLY-1) ? 2'b11 : 2'b00;
            if (i == 0) begin : g_first
                // Entry stage of the blanking delay
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)       r_blank_dly[i] <= c_rst;
                    else if (pxl_cen) r_blank_dly[i] <= {HB, VB};
                end
            end else begin : g_next
                // Shift stage of the blanking delay
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)       r_blank_dly[i] <= c_rst;
                    else if (pxl_cen) r_blank_dly[i] <= r_blank_dly[i-1];
                end
            end
        end
    endgenerate

    // Blanking that travels alongside the colour entering stage 2
    assign w_blank = |r_blank_dly[BLANK_DLY-2] | downloading | r_black;

    // Stage 2: register palette byte as 3:3:2 RGB, black when blanked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (pxl_cen) begin
            if (w_blank) begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end else begin
                r_red   <= w_pal_q[2:0];
                r_green <= w_pal_q[5:3];
                r_blue  <= w_pal_q[7:6];
            end
        end
    end

    assign red    = r_red;
    assign green  = r_green;
    assign blue   = r_blue;
    assign HB_out = r_blank_dly[BLANK_DLY-1][1];
    assign VB_out = r_blank_dly[BLANK_DLY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_jtpopeye_colmix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtpopeye_colmix
//  Brief    : Self-checking bench for jtpopeye_colmix: vector table, hand
//             sequences and a randomized stream against a palette model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtpopeye_colmix;

    logic       clk = 1'b0;
    logic       rst_n, pxl_cen, cpu_cen, pal_cs_n;
    logic [7:0] DD;
    logic [4:0] BAKC, OBJC;
    logic [3:0] TXTC;
    logic       HB, VB;
    logic [6:0] prog_addr;
    logic [7:0] prog_data;
    logic       prom_we, downloading;
    logic [2:0] gfx;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       HB_out, VB_out;

    always #5 clk = ~clk;

    jtpopeye_colmix #(.BLANK_DLY(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pxl_cen     (pxl_cen),
        .cpu_cen     (cpu_cen),
        .pal_cs_n    (pal_cs_n),
        .DD          (DD),
        .BAKC        (BAKC),
        .OBJC        (OBJC),
        .TXTC        (TXTC),
        .HB          (HB),
        .VB          (VB),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prom_we     (prom_we),
        .downloading (downloading),
`ifdef JTPOPEYE_LAYER_MASK_EN
        .gfx_en      (gfx),
`endif
        .red         (red),
        .green       (green),
        .blue        (blue),
        .HB_out      (HB_out),
        .VB_out      (VB_out)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] pal_m [128];
    bit bank_m;

    typedef struct {
        logic [7:0] rgb;
        bit hb;
        bit vb;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [4:0] bakc;
        logic [4:0] objc;
        logic [3:0] txtc;
        bit hb;
        bit vb;
        int exp_addr;   // -1: blanked
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] rgb_now();
        return {blue, green, red};
    endfunction

    // Reference: priority from layer rules, palette byte is {b,g,r}
    function automatic logic [7:0] model_rgb(input logic [4:0] bakc, input logic [4:0] objc,
                                            input logic [3:0] txtc, input bit bank,
                                            input bit hb, input bit vb, input logic [2:0] en);
        int a;
        bit black;
        black = 0;
        if (txtc != 0 && en[2])            a = 64 + int'(txtc);
        else if (objc % 4 != 0 && en[1])   a = 32 + int'(objc);
        else begin
            a = int'(bank) * 16 + int'(bakc) % 16;
            black = !en[0];
        end
        if (hb || vb || black) return 8'h00;
        return pal_m[a];
    endfunction

    task automatic pixel();
        @(negedge clk) pxl_cen = 1'b1;
        @(negedge clk) pxl_cen = 1'b0;
    endtask

    task automatic bank_write(input bit d);
        @(negedge clk) begin cpu_cen = 1'b1; pal_cs_n = 1'b0; DD = {7'h55, d}; end
        @(negedge clk) begin cpu_cen = 1'b0; pal_cs_n = 1'b1; end
        bank_m = d;
    endtask

    task automatic pal_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk) begin prog_addr = a; prog_data = d; prom_we = 1'b1; end
        @(negedge clk) prom_we = 1'b0;
        if (downloading) pal_m[a] = d;
    endtask

    // One streamed pixel; result of the previous pixel is checked after it
    task automatic step(input string name);
        exp_t e;
        e.rgb = model_rgb(BAKC, OBJC, TXTC, bank_m, HB, VB, gfx);
        e.hb = HB;
        e.vb = VB;
        q.push_back(e);
        pixel();
        if (q.size() == 2) begin
            e = q.pop_front();
            chk({name, "_rgb"}, rgb_now(), e.rgb);
            chk({name, "_hb"}, HB_out, e.hb);
            chk({name, "_vb"}, VB_out, e.vb);
        end
    endtask

    task automatic set_px(input logic [4:0] b, input logic [4:0] o, input logic [3:0] t);
        BAKC = b; OBJC = o; TXTC = t;
    endtask

    initial begin
        int hb_cnt;
        rst_n = 1'b0; pxl_cen = 1'b0; cpu_cen = 1'b0; pal_cs_n = 1'b1; DD = 8'h00;
        BAKC = 0; OBJC = 0; TXTC = 0; HB = 0; VB = 0;
        prog_addr = 0; prog_data = 0; prom_we = 0; downloading = 0; gfx = 3'b111;
        bank_m = 0;

        vecs[0] = '{5'h03, 5'h00, 4'h0, 0, 0, 'h03};
        vecs[1] = '{5'h03, 5'h05, 4'h0, 0, 0, 'h25};
        vecs[2] = '{5'h03, 5'h05, 4'h7, 0, 0, 'h47};
        vecs[3] = '{5'h03, 5'h04, 4'h0, 0, 0, 'h03};
        vecs[4] = '{5'h13, 5'h00, 4'h0, 0, 0, 'h03};
        vecs[5] = '{5'h00, 5'h1f, 4'h0, 0, 0, 'h3f};
        vecs[6] = '{5'h0f, 5'h1f, 4'hf, 0, 0, 'h4f};
        vecs[7] = '{5'h0f, 5'h08, 4'h0, 0, 0, 'h0f};
        vecs[8] = '{5'h03, 5'h05, 4'h7, 1, 0, -1};
        vecs[9] = '{5'h03, 5'h05, 4'h7, 0, 1, -1};

        repeat (3) @(negedge clk);
        chk("reset_rgb", rgb_now(), 8'h00);
        chk("reset_hb", HB_out, 1'b1);
        chk("reset_vb", VB_out, 1'b1);
        rst_n = 1'b1;

        // Palette download: entry = address ^ 5A
        downloading = 1'b1;
        for (int a = 0; a < 128; a++) pal_write(7'(a), 8'(a) ^ 8'h5A);
        downloading = 1'b0;

        // First pixel, explicit field values for entry 0x03 = 8'h59
        set_px(5'h03, 5'h00, 4'h0);
        pixel(); pixel();
        chk("first_red", red, 3'd1);
        chk("first_green", green, 3'd3);
        chk("first_blue", blue, 2'd1);
        chk("first_hb", HB_out, 1'b0);

        // Table vectors, bank 0
        foreach (vecs[i]) begin
            set_px(vecs[i].bakc, vecs[i].objc, vecs[i].txtc);
            HB = vecs[i].hb; VB = vecs[i].vb;
            pixel(); pixel();
            chk($sformatf("vec%0d_rgb", i), rgb_now(),
                vecs[i].exp_addr < 0 ? 8'h00 : pal_m[vecs[i].exp_addr]);
            chk($sformatf("vec%0d_hb", i), HB_out, vecs[i].hb);
            chk($sformatf("vec%0d_vb", i), VB_out, vecs[i].vb);
        end
        HB = 0; VB = 0;

        // Bank 1, then a bank-0 write coinciding with a pixel sample
        bank_write(1'b1);
        set_px(5'h03, 5'h00, 4'h0);
        pixel(); pixel();
        chk("bank1", rgb_now(), pal_m['h13]);
        @(negedge clk) begin pxl_cen = 1'b1; cpu_cen = 1'b1; pal_cs_n = 1'b0; DD = 8'h00; end
        @(negedge clk) begin pxl_cen = 1'b0; cpu_cen = 1'b0; pal_cs_n = 1'b1; end
        pixel();
        chk("bank_same_clk", rgb_now(), pal_m['h13]);
        bank_m = 0;
        pixel();
        chk("bank0_after", rgb_now(), pal_m['h03]);

        // HB pulse of 4 pixels
        q.delete();
        hb_cnt = 0;
        for (int j = 0; j < 10; j++) begin
            HB = (j >= 2 && j <= 5);
            step("hbpulse");
            if (HB_out) hb_cnt++;
        end
        HB = 0;
        chk("hb_pulse_len", hb_cnt, 4);

        // Randomized stream with occasional bank writes
        q.delete();
        for (int j = 0; j < 300; j++) begin
            if ($urandom_range(9) == 0) bank_write(1'($urandom));
            set_px(5'($urandom), 5'($urandom), ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0);
            HB = ($urandom_range(7) == 0);
            VB = ($urandom_range(7) == 0);
`ifdef JTPOPEYE_LAYER_MASK_EN
            gfx = 3'($urandom);
`endif
            step("rand");
        end
        HB = 0; VB = 0; gfx = 3'b111;

        // Asynchronous reset mid-line
        bank_write(1'b1);
        set_px(5'h03, 5'h00, 4'h0);
        pixel(); pixel();
        chk("pre_reset", rgb_now(), pal_m['h13]);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rgb", rgb_now(), 8'h00);
        chk("async_rst_hb", HB_out, 1'b1);
        chk("async_rst_vb", VB_out, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        bank_m = 0;
        pixel(); pixel();
        chk("post_reset_bank0", rgb_now(), pal_m['h03]);

        // Download forces black; prom_we updates entry 0x10
        downloading = 1'b1;
        pixel(); pixel();
        chk("dl_black", rgb_now(), 8'h00);
        pal_write(7'h10, 8'hA5);
        downloading = 1'b0;
        bank_write(1'b1);
        set_px(5'h00, 5'h00, 4'h0);
        pixel(); pixel();
        chk("dl_entry10", rgb_now(), 8'hA5);
        // prom_we outside download must be ignored
        pal_write(7'h11, 8'h00);
        set_px(5'h01, 5'h00, 4'h0);
        pixel(); pixel();
        chk("we_ignored", rgb_now(), 8'h4B);

`ifdef JTPOPEYE_LAYER_MASK_EN
        bank_write(1'b0);
        gfx = 3'b101;
        set_px(5'h03, 5'h05, 4'h0);
        pixel(); pixel();
        chk("mask_obj_off", rgb_now(), pal_m['h03]);
        gfx = 3'b110;
        set_px(5'h03, 5'h00, 4'h0);
        pixel(); pixel();
        chk("mask_bck_off", rgb_now(), 8'h00);
        gfx = 3'b011;
        set_px(5'h03, 5'h05, 4'h7);
        pixel(); pixel();
        chk("mask_txt_off", rgb_now(), pal_m['h25]);
        gfx = 3'b111;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
